// File: rtl/quadrature_lo_sequencer_if.sv
// Handshake and output bundle for the quadrature LO sequencer.
// master: controller side that requests start/stop and offers configs.
// slave : the sequencer itself.
//   start, stop          run control requests
//   cfg_valid/cfg_ready  config handshake, payload cfg_div/cfg_lsb
//   lo_ph, lo_i, lo_q    phase enables (lo_i = lo_ph[0], lo_q = lo_ph[1])
//   busy, cycle_strobe   run status and LO-cycle start pulse
//   cfg_applied          pulse when a config becomes active
interface quadrature_lo_sequencer_if #(
  parameter int unsigned DIV_W = 8
);
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_lsb;
  logic [3:0]       lo_ph;
  logic             lo_i;
  logic             lo_q;
  logic             busy;
  logic             cycle_strobe;
  logic             cfg_applied;

  modport master (
    output start, stop, cfg_valid, cfg_div, cfg_lsb,
    input  cfg_ready, lo_ph, lo_i, lo_q, busy, cycle_strobe, cfg_applied
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_div, cfg_lsb,
    output cfg_ready, lo_ph, lo_i, lo_q, busy, cycle_strobe, cfg_applied
  );
endinterface

// File: rtl/quadrature_lo_sequencer.sv
// Quadrature LO sequencer: four non-overlapping 25%-duty phase enables with a
// programmable quarter-period (div clks per phase) and USB/LSB rotation.
// Start, stop and config changes only take effect on LO cycle boundaries.
// Ports:
//   clk_i    system clock
//   n_rst_i  synchronous active-low reset
//   lo_if    slave side of the control/status bundle (all outputs registered)
module quadrature_lo_sequencer #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input logic                    clk_i,
  input logic                    n_rst_i,
  quadrature_lo_sequencer_if.slave lo_if
);

  // A zero quarter-period is meaningless; it is promoted to one clk.
  localparam logic [DIV_W-1:0] ResetDiv = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             lsb_q, lsb_d;
  logic [DIV_W-1:0] sdiv_q, sdiv_d;
  logic             slsb_q, slsb_d;
  logic             pend_q, pend_d;
  logic             stop_pend_q, stop_pend_d;

  logic [3:0]       lo_ph_q, lo_ph_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic             applied_q, applied_d;
  logic             ready_q, ready_d;

  logic             cfg_hs;
  logic [DIV_W-1:0] cfg_div_eff;
  logic             last_tick;
  logic             boundary;
  logic             stop_req;
  logic             cfg_commit;
  logic [1:0]       ph_sel;

  assign cfg_hs      = lo_if.cfg_valid & ready_q;
  assign cfg_div_eff = (lo_if.cfg_div == '0) ? DIV_W'(1) : lo_if.cfg_div;
  assign last_tick   = (tick_q == div_q - DIV_W'(1));
  assign boundary    = (state_q == StRun) && (phase_q == 2'd3) && last_tick;
  assign stop_req    = stop_pend_q | lo_if.stop;

  // State register
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q     <= StIdle;
      phase_q     <= 2'd0;
      tick_q      <= '0;
      div_q       <= ResetDiv;
      lsb_q       <= 1'b0;
      sdiv_q      <= ResetDiv;
      slsb_q      <= 1'b0;
      pend_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      lo_ph_q     <= 4'b0000;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      applied_q   <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      div_q       <= div_d;
      lsb_q       <= lsb_d;
      sdiv_q      <= sdiv_d;
      slsb_q      <= slsb_d;
      pend_q      <= pend_d;
      stop_pend_q <= stop_pend_d;
      lo_ph_q     <= lo_ph_d;
      busy_q      <= busy_d;
      strobe_q    <= strobe_d;
      applied_q   <= applied_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tick_d      = tick_q;
    div_d       = div_q;
    lsb_d       = lsb_q;
    sdiv_d      = sdiv_q;
    slsb_d      = slsb_q;
    pend_d      = pend_q;
    stop_pend_d = stop_pend_q;
    cfg_commit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        phase_d     = 2'd0;
        tick_d      = '0;
        stop_pend_d = 1'b0;
        // A config captured on the stopping boundary is committed here.
        if (pend_q) begin
          div_d      = sdiv_q;
          lsb_d      = slsb_q;
          pend_d     = 1'b0;
          cfg_commit = 1'b1;
        end
        if (cfg_hs) begin
          div_d      = cfg_div_eff;
          lsb_d      = lo_if.cfg_lsb;
          cfg_commit = 1'b1;
        end
        if (lo_if.start && !lo_if.stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (boundary) begin
          phase_d = 2'd0;
          tick_d  = '0;
          if (pend_q) begin
            div_d      = sdiv_q;
            lsb_d      = slsb_q;
            pend_d     = 1'b0;
            cfg_commit = 1'b1;
          end
          if (stop_req) begin
            state_d     = StIdle;
            stop_pend_d = 1'b0;
          end
        end else begin
          stop_pend_d = stop_req;
          if (last_tick) begin
            tick_d  = '0;
            phase_d = phase_q + 2'd1;
          end else begin
            tick_d = tick_q + DIV_W'(1);
          end
        end
        // Never collides with the commit above: cfg_ready is low while pending.
        if (cfg_hs) begin
          sdiv_d = cfg_div_eff;
          slsb_d = lo_if.cfg_lsb;
          pend_d = 1'b1;
        end
      end
    endcase
  end

  // Output logic (registered next values)
  always_comb begin
    // LSB rotation runs the phases backwards: index (4 - phase) mod 4.
    ph_sel    = lsb_d ? (2'd0 - phase_d) : phase_d;
    lo_ph_d   = 4'b0000;
    if (state_d == StRun) begin
      lo_ph_d[ph_sel] = 1'b1;
    end
    busy_d    = (state_d == StRun);
    strobe_d  = boundary && !stop_req;
    applied_d = cfg_commit;
    ready_d   = !pend_d;
  end

  assign lo_if.lo_ph        = lo_ph_q;
  assign lo_if.lo_i         = lo_ph_q[0];
  assign lo_if.lo_q         = lo_ph_q[1];
  assign lo_if.busy         = busy_q;
  assign lo_if.cycle_strobe = strobe_q;
  assign lo_if.cfg_applied  = applied_q;
  assign lo_if.cfg_ready    = ready_q;

endmodule

// File: tb/tb_quadrature_lo_sequencer.sv
module tb_quadrature_lo_sequencer;

  localparam int unsigned DivW       = 8;
  localparam int unsigned DefaultDiv = 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  quadrature_lo_sequencer_if #(.DIV_W(DivW)) lo_if ();

  quadrature_lo_sequencer #(
    .DIV_W      (DivW),
    .DEFAULT_DIV(DefaultDiv)
  ) u_dut (
    .clk_i  (clk),
    .n_rst_i(n_rst),
    .lo_if  (lo_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position within the LO period as a plain clk count.
  bit m_run = 0;
  int m_cnt = 0;
  int m_div = DefaultDiv;
  bit m_lsb = 0;
  int m_sdiv = 0;
  bit m_slsb = 0;
  bit m_pend = 0;
  bit m_stop = 0;
  bit m_strobe = 0;
  bit m_applied = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int exp_ph();
    int ph;
    int idx;
    if (!m_run) return 0;
    ph  = m_cnt / m_div;
    idx = m_lsb ? (4 - ph) % 4 : ph;
    return 1 << idx;
  endfunction

  task automatic model_step(input bit rst_n, input bit st, input bit sp, input bit cv,
                            input int cd, input bit cl);
    bit hs;
    bit stopping;
    int eff;
    hs = cv && !m_pend;
    eff = (cd == 0) ? 1 : cd;
    m_strobe = 0;
    m_applied = 0;
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_div = DefaultDiv; m_lsb = 0; m_pend = 0; m_stop = 0;
    end else if (!m_run) begin
      if (hs) begin m_div = eff; m_lsb = cl; m_applied = 1; end
      if (st && !sp) begin m_run = 1; m_cnt = 0; end
    end else begin
      stopping = m_stop || sp;
      if (m_cnt == 4 * m_div - 1) begin
        m_cnt = 0;
        if (m_pend) begin m_div = m_sdiv; m_lsb = m_slsb; m_pend = 0; m_applied = 1; end
        if (stopping) begin m_run = 0; m_stop = 0; end
        else m_strobe = 1;
      end else begin
        m_cnt++;
        m_stop = stopping;
      end
      if (hs) begin m_sdiv = eff; m_slsb = cl; m_pend = 1; end
    end
  endtask

  task automatic compare_all();
    logic [31:0] e;
    e = exp_ph();
    check_eq("lo_ph", 32'(lo_if.lo_ph), e);
    check_eq("lo_i", 32'(lo_if.lo_i), 32'(e[0]));
    check_eq("lo_q", 32'(lo_if.lo_q), 32'(e[1]));
    check_eq("busy", 32'(lo_if.busy), 32'(m_run));
    check_eq("cycle_strobe", 32'(lo_if.cycle_strobe), 32'(m_strobe));
    check_eq("cfg_applied", 32'(lo_if.cfg_applied), 32'(m_applied));
    check_eq("cfg_ready", 32'(lo_if.cfg_ready), 32'(!m_pend));
  endtask

  // One clk: drive, take the edge, advance the model, sample 1 ns later.
  task automatic cyc(input bit rst_n, input bit st, input bit sp, input bit cv,
                     input int cd, input bit cl);
    // A handshake on the very boundary that stops the LO is left undefined; avoid it.
    if (m_run && m_cnt == 4 * m_div - 1 && (m_stop || sp)) cv = 0;
    n_rst           = rst_n;
    lo_if.start     = st;
    lo_if.stop      = sp;
    lo_if.cfg_valid = cv;
    lo_if.cfg_div   = DivW'(cd);
    lo_if.cfg_lsb   = cl;
    @(posedge clk);
    model_step(rst_n, st, sp, cv, cd, cl);
    #1;
    compare_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic stop_and_drain();
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 1100 && m_run; i++) cyc(1, 0, 0, 0, 0, 0);
    check_eq("drained_idle", 32'(lo_if.busy), 32'd0);
  endtask

  initial begin
    lo_if.start = 0; lo_if.stop = 0; lo_if.cfg_valid = 0; lo_if.cfg_div = '0; lo_if.cfg_lsb = 0;

    // 1: reset, default div=1 USB
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check_eq("start_ph0", 32'(lo_if.lo_ph), 32'h1);
    idle_n(14);
    stop_and_drain();

    // 2: div=3 loaded in idle
    cyc(1, 0, 0, 1, 3, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle_n(26);
    stop_and_drain();

    // 3: LSB rotation, div=2
    cyc(1, 0, 0, 1, 2, 1);
    cyc(1, 1, 0, 0, 0, 0);
    idle_n(18);

    // 4: stop issued in phase 1 completes the cycle; start+stop in idle does nothing
    for (int i = 0; i < 20 && (m_cnt / m_div != 1); i++) cyc(1, 0, 0, 0, 0, 0);
    stop_and_drain();
    cyc(1, 1, 1, 0, 0, 0);
    idle_n(3);

    // 5: mid-cycle reconfiguration, then div=0
    cyc(1, 0, 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle_n(1);
    cyc(1, 0, 0, 1, 5, 0);
    idle_n(28);
    cyc(1, 0, 0, 1, 0, 0);
    idle_n(30);
    stop_and_drain();

    // 6: reset in phase 2 discards pending config and stop
    cyc(1, 0, 0, 1, 3, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && (m_cnt / m_div != 2); i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 7, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle_n(10);
    stop_and_drain();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(399) != 0),
          ($urandom_range(7) == 0),
          ($urandom_range(29) == 0),
          ($urandom_range(9) == 0),
          int'($urandom_range(6)),
          bit'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
